col_readout_sequencer: RTL and testbench
========================================

Name: col_readout_sequencer

Overview:
- Sequences readout of the 16-column pixel array for one event: scans the column hit flags, pulses the one-hot column read strobe, captures that column's 46-bit data word, tags it with the column ID and pushes it downstream through a valid/ready handshake.
- Sits between the sixteen-column array (colHitChain/colDataChain/colReadChain) and the global readout FIFO.
- Serves columns in ascending order within an event. A column is re-read until its hit flag drops.

Parameters:
- NCOL, 16: number of columns; column ID width is log2(NCOL) = 4.
- DWIDTH, 46: per-column data word width.
- DATA_LAT, 1: cycles from read strobe to valid column data (range 1..3).
- CNTWIDTH, 8: hit counter width.
- MAXHITS, 255: words pushed per event before overflow.

Ports:
- clk, in, 1: readout clock; all logic on rising edge.
- reset, in, 1: asynchronous, active-high reset.
- scanStart, in, 1: single-cycle pulse; starts an event scan.
- colHitChain, in, NCOL: per-column "has pending hit" flags.
- colDataChain, in, NCOL*DWIDTH: column c occupies bits [DWIDTH*c+DWIDTH-1 : DWIDTH*c].
- colReadChain, out, NCOL: one-hot read strobe, one cycle per word.
- dataOut, out, DWIDTH+4: {colID[3:0], colData[DWIDTH-1:0]}.
- dataValid, out, 1: dataOut valid.
- dataReady, in, 1: downstream accepts when dataValid && dataReady.
- scanBusy, out, 1: high from the cycle after scanStart until DONE.
- scanDone, out, 1: one-cycle pulse at end of scan.
- hitCount, out, CNTWIDTH: words pushed in current/last event; holds after done.
- overflow, out, 1: set when MAXHITS is exceeded in the event; cleared on scanStart.

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0, including colReadChain, dataValid, dataOut, hitCount, overflow and scanDone. Column pointer ptr=0.
- IDLE: scanBusy=0. On scanStart: clear ptr, hitCount and overflow; go to SELECT.
- SELECT: c = lowest index >= ptr with colHitChain[c]=1.
  - None found: go to DONE.
  - Found: ptr=c, go to READ.
  - Decision made in the same cycle.
- READ: colReadChain = 1<<ptr for exactly one cycle; go to WAIT.
- WAIT: DATA_LAT cycles counted from the READ cycle. In the last WAIT cycle, register the ptr slice of colDataChain, then go to PUSH. Total latency from read strobe to dataValid = DATA_LAT+1 cycles.
- PUSH:
  - If hitCount < MAXHITS: dataValid=1 and dataOut held stable until dataReady=1. On the handshake cycle hitCount increments; then go to SETTLE.
  - If hitCount == MAXHITS: the word is discarded, overflow=1, no valid is asserted, go to SETTLE in one cycle. The column is still drained.
- SETTLE: one idle cycle so the column hit flag can update; go to SELECT with ptr unchanged. The same column is re-read while its flag stays high, and later columns are served afterwards.
- DONE: scanDone=1 for one cycle, scanBusy drops; go to IDLE.
- Ordering: hits on columns below ptr that appear mid-scan are not served in this event.
- Restrictions:
  - scanStart while busy is ignored.
  - dataReady with dataValid=0 has no effect.
  - Only one colReadChain bit is ever high, and never two consecutive cycles.
- Reset mid-scan aborts immediately:
  - No scanDone pulse.
  - A pending word is lost.
  - hitCount is cleared.
- hitCount saturates at MAXHITS and never wraps.

Decomposition:
- Shared package:
  - state encoding: IDLE, SELECT, READ, WAIT, PUSH, SETTLE, DONE;
  - NCOL, DWIDTH and COLID_W=4;
  - the dataOut field offsets.
- One natural sub-module: col_priority_select. It is combinational: given the hit vector and ptr, it returns the found flag and the lowest index >= ptr.

Test Plan:
1. Single hit: colHitChain=0x0010, column 4 data=46'h1234, flag drops after read, dataReady=1.
   - One read pulse on bit 4.
   - dataOut={4'h4, 46'h1234} valid DATA_LAT+1 cycles later.
   - scanDone pulse follows; hitCount=1.
2. Multi-column order: hits on columns 15, 0 and 7, one word each.
   - Reads issued in order 0, 7, 15.
   - dataOut IDs 0, 7, 15; hitCount=3.
3. Multi-word column: column 2 holds 3 hits (flag drops after the 3rd read).
   - Three consecutive read/push cycles on column 2.
   - SETTLE cycle between each; hitCount=3.
4. Backpressure: dataReady=0 for 10 cycles during PUSH.
   - dataValid and dataOut stable throughout.
   - No new read pulse issued.
   - Word accepted on the first dataReady=1 cycle.
5. Overflow: MAXHITS=4, column 0 holds 6 hits.
   - 4 words pushed, 6 read pulses issued.
   - overflow=1, hitCount=4, scanDone pulses.
6. Reset mid-scan: assert reset during WAIT.
   - colReadChain, dataValid, scanBusy and hitCount go 0 immediately; no scanDone.
   - After release, scanStart with no hits gives scanDone 2 cycles later and hitCount=0.

Source files
------------

// File: rtl/col_readout_sequencer_pkg.sv
// Shared constants, state encoding and output field layout for the
// column readout sequencer.
package col_readout_sequencer_pkg;

    localparam int NCOL    = 16;
    localparam int DWIDTH  = 46;
    localparam int COLID_W = 4;

    // dataOut = {colID, colData}
    localparam int DATA_LSB  = 0;
    localparam int COLID_LSB = DWIDTH;
    localparam int DOUT_W    = DWIDTH + COLID_W;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        READ,
        WAIT,
        PUSH,
        SETTLE,
        DONE
    } seqState_e;

endpackage

// File: rtl/col_readout_sequencer_if.sv
// Downstream valid/ready bus carrying tagged column words to the readout FIFO.
interface col_readout_sequencer_if
    import col_readout_sequencer_pkg::*;
    ;
    logic [DOUT_W-1:0] dataOut;
    logic              dataValid;
    logic              dataReady;

    modport master (output dataOut, output dataValid, input dataReady);
    modport slave  (input dataOut, input dataValid, output dataReady);
endinterface

// File: rtl/col_priority_select.sv
// Combinational search for the lowest hit column at or above the pointer.
module col_priority_select
    import col_readout_sequencer_pkg::*;
(
    input  logic [NCOL-1:0]    hits,
    input  logic [COLID_W-1:0] ptr,
    output logic               found,
    output logic [COLID_W-1:0] idx
);

    // Walk downwards so the last match written is the lowest qualifying index.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        for (int i = NCOL - 1; i >= 0; i--) begin
            if (hits[i] && (COLID_W'(i) >= ptr)) begin
                found = 1'b1;
                idx   = COLID_W'(i);
            end
        end
    end

endmodule

// File: rtl/col_readout_sequencer.sv
// Event readout sequencer: scans column hit flags in ascending order, strobes
// one column at a time, captures its word and pushes it downstream tagged
// with the column ID. A column is re-read until its hit flag drops.
module col_readout_sequencer
    import col_readout_sequencer_pkg::*;
#(
    parameter int DATA_LAT = 1,
    parameter int CNTWIDTH = 8,
    parameter int MAXHITS  = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   scanStart,
    input  logic [NCOL-1:0]        colHitChain,
    input  logic [NCOL*DWIDTH-1:0] colDataChain,
    output logic [NCOL-1:0]        colReadChain,
    output logic                   scanBusy,
    output logic                   scanDone,
    output logic [CNTWIDTH-1:0]    hitCount,
    output logic                   overflow,
    col_readout_sequencer_if.master outBus
);

    // The WAIT countdown starts at DATA_LAT-1 so WAIT lasts DATA_LAT cycles.
    localparam logic [1:0]          WAIT_LOAD = 2'(DATA_LAT - 1);
    localparam logic [CNTWIDTH-1:0] HIT_MAX   = CNTWIDTH'(MAXHITS);

    seqState_e          state;
    logic [COLID_W-1:0] ptr;
    logic [1:0]         waitCnt;
    logic [DOUT_W-1:0]  dataOutR;
    logic               dataValidR;
    logic               selFound;
    logic [COLID_W-1:0] selIdx;

    col_priority_select uSelect (
        .hits  (colHitChain),
        .ptr   (ptr),
        .found (selFound),
        .idx   (selIdx)
    );

    assign outBus.dataOut   = dataOutR;
    assign outBus.dataValid = dataValidR;

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            waitCnt      <= '0;
            colReadChain <= '0;
            dataOutR     <= '0;
            dataValidR   <= 1'b0;
            scanBusy     <= 1'b0;
            scanDone     <= 1'b0;
            hitCount     <= '0;
            overflow     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (scanStart) begin
                        ptr      <= '0;
                        hitCount <= '0;
                        overflow <= 1'b0;
                        scanBusy <= 1'b1;
                        state    <= SELECT;
                    end
                end
                SELECT: begin
                    if (selFound) begin
                        ptr          <= selIdx;
                        colReadChain <= NCOL'(1) << selIdx;
                        state        <= READ;
                    end else begin
                        scanBusy <= 1'b0;
                        scanDone <= 1'b1;
                        state    <= DONE;
                    end
                end
                READ: begin
                    colReadChain <= '0;
                    waitCnt      <= WAIT_LOAD;
                    state        <= WAIT;
                end
                WAIT: begin
                    if (waitCnt == 2'd0) begin
                        dataOutR[COLID_LSB +: COLID_W] <= ptr;
                        dataOutR[DATA_LSB +: DWIDTH]   <= colDataChain[int'(ptr)*DWIDTH +: DWIDTH];
                        // A saturated event still drains the column but never offers the word.
                        dataValidR <= (hitCount < HIT_MAX);
                        state      <= PUSH;
                    end else begin
                        waitCnt <= waitCnt - 2'd1;
                    end
                end
                PUSH: begin
                    if (dataValidR) begin
                        if (outBus.dataReady) begin
                            dataValidR <= 1'b0;
                            hitCount   <= hitCount + 1'b1;
                            state      <= SETTLE;
                        end
                    end else begin
                        overflow <= 1'b1;
                        state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    state <= SELECT;
                end
                DONE: begin
                    scanDone <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_col_readout_sequencer.sv
// Scoreboard bench for col_readout_sequencer: a behavioural column array
// drains one hit per read strobe; expected reads and words are queued when
// an event is launched and popped as the DUT strobes and hands off words.
module tb_col_readout_sequencer;
    import col_readout_sequencer_pkg::*;

    localparam int MAXH = 4;
    localparam int LAT  = 1;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   scanStart = 1'b0;
    logic [NCOL-1:0]        colHitChain;
    logic [NCOL*DWIDTH-1:0] colDataChain;
    logic [NCOL-1:0]        colReadChain;
    logic                   scanBusy;
    logic                   scanDone;
    logic [7:0]             hitCount;
    logic                   overflow;

    col_readout_sequencer_if bus ();

    col_readout_sequencer #(
        .DATA_LAT (LAT),
        .CNTWIDTH (8),
        .MAXHITS  (MAXH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .scanStart    (scanStart),
        .colHitChain  (colHitChain),
        .colDataChain (colDataChain),
        .colReadChain (colReadChain),
        .scanBusy     (scanBusy),
        .scanDone     (scanDone),
        .hitCount     (hitCount),
        .overflow     (overflow),
        .outBus       (bus)
    );

    always #5 clk = ~clk;

    int hitsLeft [NCOL] = '{default: 0};
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int doneCount = 0;
    int firstValidCyc = -1;
    logic [DOUT_W-1:0] expWord [$];
    int expRead [$];
    int strobeCyc [$];

    function automatic logic [DWIDTH-1:0] colWord(input int c, input int n);
        return 46'h1234 ^ (DWIDTH'(c ^ 4) << 20) ^ (DWIDTH'(n) << 36);
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Column array model: flag and word of each column follow its remaining hit count.
    always_comb begin
        colHitChain  = '0;
        colDataChain = '0;
        for (int c = 0; c < NCOL; c++) begin
            colHitChain[c] = (hitsLeft[c] != 0);
            colDataChain[c*DWIDTH +: DWIDTH] = colWord(c, hitsLeft[c]);
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: read strobes, handshakes, stall stability and done pulses.
    initial begin
        logic [NCOL-1:0]   prevRead;
        logic              stallPrev;
        logic [DOUT_W-1:0] prevOut;
        int                idx;
        prevRead  = '0;
        stallPrev = 1'b0;
        prevOut   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prevRead  = '0;
                stallPrev = 1'b0;
            end else begin
                if (colReadChain != '0) begin
                    chk("read_onehot", 64'($onehot(colReadChain)), 1);
                    chk("read_back2back", 64'(prevRead), 0);
                    chk("read_while_valid", 64'(bus.dataValid), 0);
                    if (expRead.size() == 0) begin
                        chk("read_unexpected", 64'(colReadChain), 0);
                    end else begin
                        idx = expRead.pop_front();
                        chk("read_col", 64'(colReadChain), 64'(1) << idx);
                    end
                    strobeCyc.push_back(cyc);
                    for (int i = 0; i < NCOL; i++)
                        if (colReadChain[i] && hitsLeft[i] > 0) hitsLeft[i]--;
                end
                prevRead = colReadChain;
                if (stallPrev) begin
                    chk("stall_valid", 64'(bus.dataValid), 1);
                    chk("stall_data", 64'(bus.dataOut), 64'(prevOut));
                end
                if (bus.dataValid) begin
                    if (firstValidCyc < 0) firstValidCyc = cyc;
                    if (bus.dataReady) begin
                        if (expWord.size() == 0) chk("word_unexpected", 64'(bus.dataOut), 0);
                        else chk("word", 64'(bus.dataOut), 64'(expWord.pop_front()));
                    end
                end
                stallPrev = bus.dataValid && !bus.dataReady;
                prevOut   = bus.dataOut;
                if (scanDone) doneCount++;
            end
        end
    end

    task automatic pulseStart();
        @(negedge clk);
        scanStart = 1'b1;
        @(negedge clk);
        scanStart = 1'b0;
    endtask

    // Queue the expected reads/words for the hits currently loaded, run the event, check the totals.
    task automatic runEvent();
        int total;
        int nWords;
        bit seen;
        total  = 0;
        nWords = 0;
        seen   = 1'b0;
        for (int c = 0; c < NCOL; c++) begin
            for (int k = 1; k <= hitsLeft[c]; k++) begin
                expRead.push_back(c);
                if (nWords < MAXH) begin
                    expWord.push_back({COLID_W'(c), colWord(c, hitsLeft[c] - k)});
                    nWords++;
                end
                total++;
            end
        end
        strobeCyc.delete();
        firstValidCyc = -1;
        doneCount     = 0;
        pulseStart();
        chk("busy_after_start", 64'(scanBusy), 1);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (scanDone) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 64'(seen), 1);
        chk("busy_at_done", 64'(scanBusy), 0);
        @(negedge clk);
        #1;
        chk("done_count", 64'(doneCount), 1);
        chk("hit_count", 64'(hitCount), 64'(nWords));
        chk("overflow", 64'(overflow), 64'(total > MAXH));
        chk("words_left", 64'(expWord.size()), 0);
        chk("reads_left", 64'(expRead.size()), 0);
        chk("reads_total", 64'(strobeCyc.size()), 64'(total));
    endtask

    initial begin
        bit seen;
        bus.dataReady = 1'b1;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_read", 64'(colReadChain), 0);
        chk("rst_valid", 64'(bus.dataValid), 0);
        chk("rst_dout", 64'(bus.dataOut), 0);
        chk("rst_hits", 64'(hitCount), 0);
        chk("rst_ovf", 64'(overflow), 0);
        chk("rst_done", 64'(scanDone), 0);
        chk("rst_busy", 64'(scanBusy), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // single hit on column 4
        hitsLeft[4] = 1;
        runEvent();
        chk("t1_latency", strobeCyc.size() > 0 ? 64'(firstValidCyc - strobeCyc[0]) : 64'hFFFF, LAT + 1);

        // ascending order across columns 15, 0, 7
        hitsLeft[15] = 1;
        hitsLeft[0]  = 1;
        hitsLeft[7]  = 1;
        runEvent();

        // three words from one column, SETTLE between each
        hitsLeft[2] = 3;
        runEvent();
        for (int i = 1; i < strobeCyc.size(); i++)
            chk("t3_read_gap", 64'(strobeCyc[i] - strobeCyc[i-1]), 5);

        // backpressure for 10 cycles during PUSH
        hitsLeft[9] = 1;
        bus.dataReady = 1'b0;
        fork
            runEvent();
            begin
                seen = 1'b0;
                for (int n = 0; n < 200; n++) begin
                    @(negedge clk);
                    if (bus.dataValid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                chk("t4_valid_seen", 64'(seen), 1);
                repeat (10) @(negedge clk);
                @(posedge clk);
                #1 bus.dataReady = 1'b1;
                @(negedge clk);
                @(negedge clk);
                chk("t4_accept_first_ready", 64'(bus.dataValid), 0);
            end
        join

        // overflow: six hits, four words allowed
        hitsLeft[0] = 6;
        runEvent();
        repeat (3) @(negedge clk);
        chk("t5_hits_hold", 64'(hitCount), MAXH);
        chk("t5_ovf_hold", 64'(overflow), 1);

        // reset during WAIT of the second word
        hitsLeft[3] = 2;
        expRead.push_back(3);
        expRead.push_back(3);
        expWord.push_back({COLID_W'(3), colWord(3, 1)});
        strobeCyc.delete();
        doneCount = 0;
        pulseStart();
        for (int n = 0; n < 200 && strobeCyc.size() < 2; n++) @(negedge clk);
        chk("t6_second_read", 64'(strobeCyc.size()), 2);
        chk("t6_ovf_cleared", 64'(overflow), 0);
        @(posedge clk);
        #1;
        chk("t6_pre_hits", 64'(hitCount), 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_read", 64'(colReadChain), 0);
        chk("t6_rst_valid", 64'(bus.dataValid), 0);
        chk("t6_rst_busy", 64'(scanBusy), 0);
        chk("t6_rst_hits", 64'(hitCount), 0);
        repeat (3) @(negedge clk);
        chk("t6_no_done", 64'(scanDone), 0);
        expWord.delete();
        expRead.delete();
        for (int c = 0; c < NCOL; c++) hitsLeft[c] = 0;
        reset = 1'b0;
        @(negedge clk);
        chk("t6_no_done_count", 64'(doneCount), 0);
        scanStart = 1'b1;
        @(negedge clk);
        scanStart = 1'b0;
        chk("t6_done_early", 64'(scanDone), 0);
        @(negedge clk);
        chk("t6_done_2cyc", 64'(scanDone), 1);
        chk("t6_hits_zero", 64'(hitCount), 0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
